data_memory_wait: RTL
=====================

// Module: data_memory_wait
// PURPOSE
//   Word-addressed data memory for the MEM stage with configurable wait-state latency.
//   Accepts one read or write at a time and holds `ready` low until the access completes.
//   The pipeline stalls on ~ready.
//   Adds parametrised width, depth, base address, range checking and a request FSM.
// PARAMETERS
//   DATA_W      32    data word width (bits)
//   ADDR_W      32    byte-address width (bits)
//   DEPTH       64    number of words; index width = clog2(DEPTH)
//   BASE_ADDR   1024  byte address mapped to word 0
//   WAIT_CYCLES 4     BUSY cycles per access; legal range >= 1
// PORTS
//   clk       in   1       rising-edge clock
//   rst_n     in   1       asynchronous active-low reset
//   mem_w_en  in   1       write request, held until ready=1
//   mem_r_en  in   1       read request, held until ready=1
//   alu_res   in   ADDR_W  byte address
//   val_rm    in   DATA_W  write data
//   ready     out  1       0 = stall pipeline; 1 = idle or access complete this cycle
//   out       out  DATA_W  read data, registered; valid from the DONE cycle
//   addr_err  out  1       1-cycle pulse in DONE when the latched address was out of range
// BEHAVIOUR
//   Reset (async, rst_n=0)
//     - state=IDLE, cnt=0, out=0, addr_err=0.
//     - Memory array is NOT cleared.
//     - An in-flight access is aborted: no write is committed.
//   Address arithmetic (ADDR_W-bit unsigned)
//     - off = alu_res - BASE_ADDR; idx = off >> 2; off[1:0] is ignored.
//     - in_range = (off < DEPTH*4). Addresses below BASE_ADDR wrap to large off and are out of range.
//   FSM
//     IDLE : ready = ~(mem_w_en | mem_r_en), combinational.
//            On a request: latch idx, in_range, val_rm, and op (W if mem_w_en, else R).
//            Then cnt <= WAIT_CYCLES-1 and go to BUSY.
//            Both enables high -> treat as write; the read is dropped.
//     BUSY : ready=0. Count cnt down each cycle.
//            At cnt==0, go to DONE. On that same edge:
//              W & in_range  : mem[idx] <= data
//              R & in_range  : out <= mem[idx]
//              R & !in_range : out <= 0
//              !in_range     : addr_err <= 1 (any op)
//     DONE : ready=1 and addr_err as set. Go to IDLE unconditionally.
//            Inputs are ignored this cycle, because the requester is still holding the
//            same request while it advances.
//            Next edge: addr_err <= 0.
//   Latency
//     - ready is low for WAIT_CYCLES+1 cycles per access (IDLE request cycle + WAIT_CYCLES BUSY).
//     - Back-to-back accesses: the next request is seen in IDLE one cycle after DONE.
//   Inputs are sampled only in the IDLE request cycle. Changes during BUSY have no effect.
//   out holds its value across writes and idle cycles; it changes only when a read completes.
//   Read-after-write to the same index returns the new data, because accesses are sequential.
// TESTING (WAIT_CYCLES=4, defaults otherwise)
//   1. Reset: rst_n=0 mid-BUSY write of 0x55 to 1024 -> ready=1, out=0, addr_err=0;
//      a later read of 1024 must not return 0x55.
//   2. Write 0xDEADBEEF @1024, then read @1024 -> ready low exactly 5 cycles per access;
//      out=0xDEADBEEF in the read DONE cycle.
//   3. Write 0x12345678 @1276 (idx 63), read @1279 -> 0x12345678 (low bits ignored);
//      addr_err stays 0.
//   4. Write 0x1 @1280 and read @1020 -> addr_err pulses 1 cycle each; out=0 after the read;
//      mem[0] and mem[63] unchanged.
//   5. mem_w_en=mem_r_en=1 @1028 with val_rm=0xA5A5A5A5 -> write committed; out unchanged;
//      a later read @1028 gives 0xA5A5A5A5.
//   6. Change alu_res/val_rm every BUSY cycle; hold the request through DONE ->
//      exactly one access to the originally latched address, with no re-trigger in DONE.

Source files
------------

// File: rtl/data_memory_wait_if.sv
// Request/response bundle between a MEM-stage requester and data_memory_wait.
// The requester holds mem_w_en/mem_r_en with alu_res/val_rm until it sees ready=1.
interface data_memory_wait_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              mem_w_en;
    logic              mem_r_en;
    logic [ADDR_W-1:0] alu_res;
    logic [DATA_W-1:0] val_rm;
    logic              ready;
    logic [DATA_W-1:0] out;
    logic              addr_err;

    modport master (
        output mem_w_en,
        output mem_r_en,
        output alu_res,
        output val_rm,
        input  ready,
        input  out,
        input  addr_err
    );

    modport slave (
        input  mem_w_en,
        input  mem_r_en,
        input  alu_res,
        input  val_rm,
        output ready,
        output out,
        output addr_err
    );
endinterface

// File: rtl/data_memory_wait.sv
// Word-addressed data memory with a fixed number of wait states per access.
// One access at a time: IDLE latches the request, BUSY counts WAIT_CYCLES,
// DONE reports completion for one cycle while the requester still holds its request.
module data_memory_wait #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 64,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    data_memory_wait_if.slave   bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(WAIT_CYCLES) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(DEPTH * 4);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_op_w;
    logic              r_in_range;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_out;
    logic              r_addr_err;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [ADDR_W-1:0] w_off;
    logic              w_in_range;
    logic [IDX_W-1:0]  w_idx;
    logic              w_req;
    logic              w_commit;
    logic              w_ready;

    // Addresses below BASE wrap to a huge offset, so one unsigned compare covers both ends.
    assign w_off      = bus.alu_res - BASE;
    assign w_in_range = (w_off < SPAN);
    assign w_idx      = w_off[IDX_W+1:2];
    assign w_req      = bus.mem_w_en | bus.mem_r_en;
    assign w_commit   = (r_state == S_BUSY) && (r_cnt == '0);

    // Stall the pipeline whenever an access is pending or in progress.
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            S_IDLE:  w_ready = ~w_req;
            S_BUSY:  w_ready = 1'b0;
            S_DONE:  w_ready = 1'b1;
            default: w_ready = 1'b0;
        endcase
    end

    // Request FSM: latch in IDLE, count in BUSY, report in DONE; DONE ignores the held request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_op_w     <= 1'b0;
            r_in_range <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_out      <= '0;
            r_addr_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_addr_err <= 1'b0;
                    if (w_req) begin
                        r_op_w     <= bus.mem_w_en;
                        r_in_range <= w_in_range;
                        r_idx      <= w_idx;
                        r_wdata    <= bus.val_rm;
                        r_cnt      <= CNT_W'(WAIT_CYCLES - 1);
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= S_DONE;
                        if (!r_in_range) begin
                            r_addr_err <= 1'b1;
                        end
                        if (!r_op_w) begin
                            r_out <= r_in_range ? r_mem[r_idx] : '0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    r_addr_err <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Array write on the last BUSY edge; a reset forces IDLE first, so an aborted write never lands.
    always_ff @(posedge clk) begin
        if (w_commit && r_op_w && r_in_range) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign bus.ready    = w_ready;
    assign bus.out      = r_out;
    assign bus.addr_err = r_addr_err;
endmodule
